// File: rtl/ex_flag_stage.sv
// rtl/ex_flag_stage.sv - EX/MEM pipeline register with Z/V/N flags, branch evaluation and overflow counter
// Flags are {Z,V,N}; branch decisions use the forwarded next-flags value.

module ex_flag_stage #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_in,
   input  logic             stall,
   input  logic             flush,
   input  logic [3:0]       opcode,
   input  logic [15:0]      alu_result,
   input  logic             alu_ovfl,
   input  logic [3:0]       dst_in,
   input  logic             wr_en_in,
   input  logic [2:0]       cond,
   input  logic             clr_cnt,
   output logic             valid_out,
   output logic [15:0]      result_out,
   output logic [3:0]       dst_out,
   output logic             wr_en_out,
   output logic [2:0]       flags,
   output logic             br_taken,
   output logic [CNT_W-1:0] ovfl_cnt
);

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_XOR = 4'b0010;
   localparam logic [3:0] OP_SLL = 4'b0100;
   localparam logic [3:0] OP_SRA = 4'b0101;
   localparam logic [3:0] OP_ROR = 4'b0110;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic       accept;
   logic       is_arith;
   logic       is_zonly;
   logic       res_zero;
   logic [2:0] flags_next;
   logic       z_n, v_n, n_n;

   assign accept   = valid_in & ~stall & ~flush;
   assign is_arith = (opcode == OP_ADD) | (opcode == OP_SUB);
   assign is_zonly = (opcode == OP_XOR) | (opcode == OP_SLL) |
                     (opcode == OP_SRA) | (opcode == OP_ROR);
   assign res_zero = (alu_result == 16'h0000);

   always_comb begin
      flags_next = flags;
      if (accept && is_arith)
         flags_next = {res_zero, alu_ovfl, alu_result[15]};
      else if (accept && is_zonly)
         flags_next = {res_zero, flags[1], flags[0]};
   end

   assign z_n = flags_next[2];
   assign v_n = flags_next[1];
   assign n_n = flags_next[0];

   // Forwarded flags let a branch in ID see the op currently in EX.
   always_comb begin
      br_taken = 1'b0;
      case (cond)
         3'b000:  br_taken = ~z_n;
         3'b001:  br_taken = z_n;
         3'b010:  br_taken = ~z_n & ~n_n;
         3'b011:  br_taken = n_n;
         3'b100:  br_taken = z_n | ~n_n;
         3'b101:  br_taken = n_n | z_n;
         3'b110:  br_taken = v_n;
         default: br_taken = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_out  <= 1'b0;
         result_out <= 16'h0000;
         dst_out    <= 4'h0;
         wr_en_out  <= 1'b0;
         flags      <= 3'b000;
         ovfl_cnt   <= '0;
      end else begin
         flags <= flags_next;

         // Clear beats increment and is honoured even while stalled.
         if (clr_cnt)
            ovfl_cnt <= '0;
         else if (accept && is_arith && alu_ovfl && (ovfl_cnt != CNT_MAX))
            ovfl_cnt <= ovfl_cnt + 1'b1;

         if (flush) begin
            valid_out <= 1'b0;
            wr_en_out <= 1'b0;
         end else if (!stall) begin
            if (valid_in) begin
               valid_out  <= 1'b1;
               result_out <= alu_result;
               dst_out    <= dst_in;
               wr_en_out  <= wr_en_in;
            end else begin
               valid_out <= 1'b0;
               wr_en_out <= 1'b0;
            end
         end
      end
   end

endmodule
